e203_exu_oitf_mp: RTL
=====================

Name: e203_exu_oitf_mp

Overview:
Parametrised outstanding-instruction-track FIFO for the EXU. It records the destination register, FPU flag and PC of every dispatched long-pipe instruction until that instruction retires. It generalises the fixed 2-entry OITF in four ways:
- configurable depth;
- occupancy count and full flag;
- synchronous flush;
- the pointer of the youngest entry that collides with the dispatching instruction's rd.

It sits between the dispatch unit (hazard checks) and the long-pipe writeback arbiter (in-order retire).

Parameters:
DEPTH, 2, number of entries; power of two, minimum 2
PTR_W, $clog2(DEPTH), entry pointer width (derived, not overridden)
RFIDX_WIDTH, 5, register index width
PC_SIZE, 32, PC width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries
dis_ena  in  1  allocate entry at dis_ptr this cycle
dis_ready  out  1  FIFO not full
dis_ptr  out  PTR_W  next allocation pointer
ret_ena  in  1  retire oldest entry this cycle
ret_ptr  out  PTR_W  oldest entry pointer
ret_rdidx  out  RFIDX_WIDTH  rd index of oldest entry
ret_rdwen  out  1  rd write-enable of oldest entry
ret_rdfpu  out  1  rd is FPU register
ret_pc  out  PC_SIZE  PC of oldest entry
disp_i_rs1en/rs2en/rs3en/rdwen  in  1 each  operand enables of dispatching instruction
disp_i_rs1fpu/rs2fpu/rs3fpu/rdfpu  in  1 each  operand FPU flags
disp_i_rs1idx/rs2idx/rs3idx/rdidx  in  RFIDX_WIDTH each  operand indices
disp_i_pc  in  PC_SIZE  PC of dispatching instruction
oitfrd_match_disprs1/rs2/rs3/rd  out  1 each  any valid entry's rd collides with that operand
oitfrd_match_disprd_ptr  out  PTR_W  pointer of youngest entry colliding with disp rd
oitf_empty  out  1  no valid entries
oitf_full  out  1  all entries valid
oitf_count  out  PTR_W+1  number of valid entries

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - pointers 0, wrap bits 0, all valid bits 0;
  - entry payload (rdidx, rdwen, rdfpu, pc) cleared to 0;
  - resulting outputs: dis_ready=1, oitf_empty=1, oitf_full=0, oitf_count=0, every match output 0, ret_* all 0.
- Pointers: dis_ptr and ret_ptr are PTR_W bits, each with an extra wrap bit. They increment modulo DEPTH and toggle the wrap bit on passing DEPTH-1→0.
  - empty = pointers equal and wrap bits equal.
  - full = pointers equal and wrap bits different.
- Dispatch:
  - A dispatch is accepted when dis_ena && dis_ready.
  - On acceptance, the entry at dis_ptr gets valid=1 and {rdidx, rdwen, rdfpu, pc} from the disp_i_* inputs; dis_ptr advances.
  - dis_ena while full is ignored; no state changes.
  - dis_ready = !oitf_full. There is no same-cycle retire bypass, so when full, a dispatch must wait one cycle after a retire.
- Retire:
  - A retire is accepted when ret_ena && !oitf_empty. It clears the valid bit at ret_ptr and ret_ptr advances.
  - ret_ena while empty is ignored.
  - ret_* are combinational from the entry at ret_ptr, forced to 0 while empty.
- Dispatch and retire in the same cycle: both take effect and oitf_count is unchanged. With DEPTH=2 and one entry valid, this legally cycles dis_ptr/ret_ptr through the wrap.
- Flush:
  - Takes effect on the next edge and overrides dis_ena and ret_ena in the same cycle.
  - Clears all valid bits, both pointers and both wrap bits.
  - Payload is retained, but outputs are gated by valid/empty, so stale payload is never visible.
- Match outputs:
  - Purely combinational from registered state. An instruction dispatching in the current cycle is not included.
  - Per-entry collision = valid && rdwen && (rdidx == srcidx) && (rdfpu == srcfpu).
  - oitfrd_match_disprsN = OR over entries of the collision, gated by disp_i_rsNen.
  - oitfrd_match_disprd = OR over entries of the collision, gated by disp_i_rdwen.
- Youngest-match pointer (oitfrd_match_disprd_ptr):
  - Scan from dis_ptr-1 backward toward ret_ptr, modulo DEPTH.
  - Output the first colliding entry found.
  - Output 0 when oitfrd_match_disprd=0.
- Count: oitf_count = (dis_ptr with wrap bit) − (ret_ptr with wrap bit), modulo 2·DEPTH. Range is 0..DEPTH.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

Decomposition:
- Package e203_oitf_pkg holds:
  - the entry struct typedef {rdidx, rdwen, rdfpu, pc}, parametrised by RFIDX_WIDTH and PC_SIZE through localparams;
  - the ptr_inc function (increment with wrap-bit toggle).
- One sub-module: e203_oitf_youngest_sel. It is a combinational circular priority selector taking a DEPTH-bit collision vector and a start pointer, and returning the youngest hit pointer plus a hit flag.
- The entry array, pointer logic and comparators stay in the top.

Test Plan:
1. Reset then idle → dis_ready=1, oitf_empty=1, oitf_count=0, ret_pc=0, all match outputs 0.
2. DEPTH=4: dispatch rd=x5 (pc=0x100), x6 (0x104), x5 (0x108), x7 (0x10C) → oitf_full=1, dis_ready=0, count=4. A fifth dis_ena is ignored. ret_pc=0x100.
3. Continuing from 2: rs1idx=5, rs1en=1, rdidx=5, rdwen=1 → match_disprs1=1, match_disprd=1, match_disprd_ptr=2. With rs1fpu=1 instead → match_disprs1=0.
4. Retire 4 times (ret_pc 0x100, 0x104, 0x108, 0x10C in order) → empty=1, ret_* all 0. An extra ret_ena causes no change.
5. One entry valid, dis_ena and ret_ena held together for 6 cycles → count stays 1, and both pointers wrap past 3→0 without an empty/full glitch.
6. Three entries valid, flush with dis_ena=1 and ret_ena=1 in the same cycle → next cycle count=0, empty=1, dis_ptr=0, ret_ptr=0. A following dispatch lands at entry 0.

Source files
------------

// File: rtl/e203_oitf_pkg.sv
// Shared types and helpers for the outstanding-instruction-track FIFO.
package e203_oitf_pkg;

   localparam int OITF_RFIDX_W = 5;
   localparam int OITF_PC_W    = 32;

   // Payload recorded for each in-flight long-pipe instruction.
   typedef struct packed {
      logic [OITF_RFIDX_W-1:0] rdidx;
      logic                    rdwen;
      logic                    rdfpu;
      logic [OITF_PC_W-1:0]    pc;
   } oitf_entry_t;

   // Advance a pointer that carries a wrap bit above ptr_w index bits.
   // DEPTH is a power of two, so a plain binary increment of {wrap, idx}
   // wraps the index modulo DEPTH and toggles the wrap bit on DEPTH-1 -> 0.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned ptr_w);
      logic [31:0] mask;
      mask = (32'd1 << (ptr_w + 1)) - 32'd1;
      return (ptr + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/e203_oitf_youngest_sel.sv
// Circular priority selector: starting at start_ptr and walking backward,
// returns the first set bit of hit_vec (the youngest colliding entry).
module e203_oitf_youngest_sel
   import e203_oitf_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] hit_vec,
   input  logic [PTR_W-1:0] start_ptr,
   output logic [PTR_W-1:0] sel_ptr,
   output logic             hit
);

   logic [PTR_W-1:0] scan_idx;

   // Scan oldest-to-youngest so the youngest hit overwrites earlier ones.
   always_comb begin
      sel_ptr  = '0;
      hit      = 1'b0;
      scan_idx = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         scan_idx = start_ptr - PTR_W'(k);
         if (hit_vec[scan_idx]) begin
            sel_ptr = scan_idx;
            hit     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/e203_exu_oitf_mp.sv
// Outstanding-instruction-track FIFO: records rd/FPU flag/PC of dispatched
// long-pipe instructions until in-order retire, with hazard match outputs.
module e203_exu_oitf_mp
   import e203_oitf_pkg::*;
#(
   parameter  int DEPTH       = 2,
   localparam int PTR_W       = $clog2(DEPTH),
   parameter  int RFIDX_WIDTH = OITF_RFIDX_W,
   parameter  int PC_SIZE     = OITF_PC_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   dis_ena,
   output logic                   dis_ready,
   output logic [PTR_W-1:0]       dis_ptr,
   input  logic                   ret_ena,
   output logic [PTR_W-1:0]       ret_ptr,
   output logic [RFIDX_WIDTH-1:0] ret_rdidx,
   output logic                   ret_rdwen,
   output logic                   ret_rdfpu,
   output logic [PC_SIZE-1:0]     ret_pc,
   input  logic                   disp_i_rs1en,
   input  logic                   disp_i_rs2en,
   input  logic                   disp_i_rs3en,
   input  logic                   disp_i_rdwen,
   input  logic                   disp_i_rs1fpu,
   input  logic                   disp_i_rs2fpu,
   input  logic                   disp_i_rs3fpu,
   input  logic                   disp_i_rdfpu,
   input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
   input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
   input  logic [RFIDX_WIDTH-1:0] disp_i_rs3idx,
   input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
   input  logic [PC_SIZE-1:0]     disp_i_pc,
   output logic                   oitfrd_match_disprs1,
   output logic                   oitfrd_match_disprs2,
   output logic                   oitfrd_match_disprs3,
   output logic                   oitfrd_match_disprd,
   output logic [PTR_W-1:0]       oitfrd_match_disprd_ptr,
   output logic                   oitf_empty,
   output logic                   oitf_full,
   output logic [PTR_W:0]         oitf_count
);

   // Pointers carry a wrap bit in the MSB to tell full from empty.
   logic [PTR_W:0]   dis_ptr_reg, dis_ptr_next;
   logic [PTR_W:0]   ret_ptr_reg, ret_ptr_next;
   logic [DEPTH-1:0] valid_reg;
   oitf_entry_t      entries_reg [DEPTH];

   logic [PTR_W-1:0] dis_idx, ret_idx;
   logic             dis_fire, ret_fire;
   oitf_entry_t      ret_entry;

   logic [DEPTH-1:0] coll_rs1, coll_rs2, coll_rs3, coll_rd;
   logic             youngest_hit;

   assign dis_idx = dis_ptr_reg[PTR_W-1:0];
   assign ret_idx = ret_ptr_reg[PTR_W-1:0];

   assign oitf_empty = (dis_ptr_reg == ret_ptr_reg);
   assign oitf_full  = (dis_idx == ret_idx) && (dis_ptr_reg[PTR_W] != ret_ptr_reg[PTR_W]);
   assign oitf_count = dis_ptr_reg - ret_ptr_reg;
   assign dis_ready  = ~oitf_full;
   assign dis_ptr    = dis_idx;
   assign ret_ptr    = ret_idx;

   // Flush wins over both handshakes; full/empty block the respective side.
   assign dis_fire = dis_ena & ~oitf_full & ~flush;
   assign ret_fire = ret_ena & ~oitf_empty & ~flush;

   assign dis_ptr_next = (PTR_W+1)'(ptr_inc(32'(dis_ptr_reg), PTR_W));
   assign ret_ptr_next = (PTR_W+1)'(ptr_inc(32'(ret_ptr_reg), PTR_W));

   // Pointer registers: advance on accepted handshakes, clear on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dis_ptr_reg <= '0;
         ret_ptr_reg <= '0;
      end else if (flush) begin
         dis_ptr_reg <= '0;
         ret_ptr_reg <= '0;
      end else begin
         if (dis_fire) dis_ptr_reg <= dis_ptr_next;
         if (ret_fire) ret_ptr_reg <= ret_ptr_next;
      end
   end

   // Valid bits and payload; flush drops validity but keeps stale payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
         for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
      end else if (flush) begin
         valid_reg <= '0;
      end else begin
         if (ret_fire) valid_reg[ret_idx] <= 1'b0;
         if (dis_fire) begin
            valid_reg[dis_idx]   <= 1'b1;
            entries_reg[dis_idx] <= '{rdidx: disp_i_rdidx, rdwen: disp_i_rdwen,
                                      rdfpu: disp_i_rdfpu, pc: disp_i_pc};
         end
      end
   end

   // Oldest entry is presented to the writeback arbiter, zeroed when empty.
   assign ret_entry = oitf_empty ? '0 : entries_reg[ret_idx];
   assign ret_rdidx = ret_entry.rdidx;
   assign ret_rdwen = ret_entry.rdwen;
   assign ret_rdfpu = ret_entry.rdfpu;
   assign ret_pc    = ret_entry.pc;

   // Per-entry rd collision against each operand of the dispatching instruction.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_coll
      logic live;
      assign live = valid_reg[gi] & entries_reg[gi].rdwen;
      assign coll_rs1[gi] = live && (entries_reg[gi].rdidx == disp_i_rs1idx)
                                 && (entries_reg[gi].rdfpu == disp_i_rs1fpu);
      assign coll_rs2[gi] = live && (entries_reg[gi].rdidx == disp_i_rs2idx)
                                 && (entries_reg[gi].rdfpu == disp_i_rs2fpu);
      assign coll_rs3[gi] = live && (entries_reg[gi].rdidx == disp_i_rs3idx)
                                 && (entries_reg[gi].rdfpu == disp_i_rs3fpu);
      assign coll_rd[gi]  = live && (entries_reg[gi].rdidx == disp_i_rdidx)
                                 && (entries_reg[gi].rdfpu == disp_i_rdfpu)
                                 && disp_i_rdwen;
   end

   assign oitfrd_match_disprs1 = disp_i_rs1en & (|coll_rs1);
   assign oitfrd_match_disprs2 = disp_i_rs2en & (|coll_rs2);
   assign oitfrd_match_disprs3 = disp_i_rs3en & (|coll_rs3);
   assign oitfrd_match_disprd  = |coll_rd;

   // Valid entries are contiguous behind dis_ptr, so scanning backward from
   // dis_ptr-1 meets the youngest collision first.
   e203_oitf_youngest_sel #(.DEPTH(DEPTH)) u_youngest_sel (
      .hit_vec   (coll_rd),
      .start_ptr (dis_idx - PTR_W'(1)),
      .sel_ptr   (oitfrd_match_disprd_ptr),
      .hit       (youngest_hit)
   );

   logic unused_hit;
   assign unused_hit = youngest_hit;

endmodule
